// File: rtl/dlock_code_ctrl_if.sv
// ----------------------------------------------------------------------------
// dlock_code_ctrl_if
//   Bundle of signals between the keypad entry FSM (master) and the
//   code/strike/lockout controller (slave).
//
//   Full_Input [15:0]  assembled code from the entry FSM
//   counter    [1:0]   digit index; 2'b11 means the fourth digit is present
//   lock               unlock pulse from the entry FSM
//   Error              error level from the entry FSM
//   Prog               request to replace the stored code with Code_In
//   Code_In    [15:0]  new passcode
//   lockcomp           registered match flag back to the entry FSM
//   strike             door strike drive
//   lockout            keypad disabled indicator
//   fail_cnt   [FW-1:0] consecutive failure count
//   prog_ack           one-cycle pulse, new code accepted
// ----------------------------------------------------------------------------
interface dlock_code_ctrl_if #(
    parameter int MAX_FAIL = 3
);
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic [15:0]   Full_Input;
    logic [1:0]    counter;
    logic          lock;
    logic          Error;
    logic          Prog;
    logic [15:0]   Code_In;
    logic          lockcomp;
    logic          strike;
    logic          lockout;
    logic [FW-1:0] fail_cnt;
    logic          prog_ack;

    // Entry-FSM / programming side.
    modport master (
        output Full_Input, counter, lock, Error, Prog, Code_In,
        input  lockcomp, strike, lockout, fail_cnt, prog_ack
    );

    // Code controller side.
    modport slave (
        input  Full_Input, counter, lock, Error, Prog, Code_In,
        output lockcomp, strike, lockout, fail_cnt, prog_ack
    );
endinterface

// File: rtl/dlock_code_ctrl.sv
// ----------------------------------------------------------------------------
// dlock_code_ctrl
//   Downstream companion of the keypad entry FSM. Holds the stored passcode
//   and returns a registered compare result, stretches the unlock pulse into
//   a timed strike drive, counts failed attempts and enforces a timed keypad
//   lockout, and accepts a new passcode only while the door is unlocked.
//
//   clk    in  clock
//   Reset  in  synchronous, active-high reset
//   bus    slave side of dlock_code_ctrl_if (entry FSM inputs, status outputs)
// ----------------------------------------------------------------------------
module dlock_code_ctrl #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int          STRIKE_CYCLES  = 8,
    parameter int          LOCKOUT_CYCLES = 32,
    parameter int          MAX_FAIL       = 3
) (
    input  logic               clk,
    input  logic               Reset,
    dlock_code_ctrl_if.slave   bus
);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (STRIKE_CYCLES > LOCKOUT_CYCLES) ? STRIKE_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] STRIKE_LOAD  = TW'(STRIKE_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX     = FW'(MAX_FAIL);
    localparam logic [FW-1:0] FAIL_LAST    = FW'(MAX_FAIL - 1);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [15:0]     r_code;
    logic            r_lock_q;
    logic            r_err_q;
    logic            r_lockcomp;
    logic            r_strike;
    logic            r_lockout;
    logic [FW-1:0]   r_fail_cnt;
    logic            r_prog_ack;

    logic            w_lock_rise;
    logic            w_error_rise;

    assign w_lock_rise  = bus.lock  & ~r_lock_q;
    assign w_error_rise = bus.Error & ~r_err_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= ST_ARMED;
            r_timer    <= '0;
            // NOTE: the code register is reset on purpose so that a code
            // loaded through Prog is discarded and DEFAULT_CODE returns.
            r_code     <= DEFAULT_CODE;
            r_lock_q   <= 1'b0;
            r_err_q    <= 1'b0;
            r_lockcomp <= 1'b0;
            r_strike   <= 1'b0;
            r_lockout  <= 1'b0;
            r_fail_cnt <= '0;
            r_prog_ack <= 1'b0;
        end else begin
            // NOTE: every state update here is non-blocking, so all reads in
            // this block see the values from before the current clock edge.
            r_lock_q   <= bus.lock;
            r_err_q    <= bus.Error;
            r_lockcomp <= (bus.counter == 2'b11) && (bus.Full_Input == r_code)
                          && (r_state != ST_LOCKOUT);
            r_prog_ack <= 1'b0;

            case (r_state)
                ST_ARMED: begin
                    // An unlock beats a simultaneous error edge.
                    if (w_lock_rise) begin
                        r_state    <= ST_UNLOCKED;
                        r_timer    <= STRIKE_LOAD;
                        r_fail_cnt <= '0;
                        r_strike   <= 1'b1;
                    end else if (w_error_rise) begin
                        if (r_fail_cnt == FAIL_LAST) begin
                            r_state    <= ST_LOCKOUT;
                            r_timer    <= LOCKOUT_LOAD;
                            r_fail_cnt <= FAIL_MAX;
                            r_lockout  <= 1'b1;
                        end else if (r_fail_cnt < FAIL_MAX) begin
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                    end
                end

                ST_UNLOCKED: begin
                    if (bus.Prog) begin
                        r_code     <= bus.Code_In;
                        r_prog_ack <= 1'b1;
                    end
                    // A fresh unlock restarts the full strike window, even
                    // in what would have been the last strike cycle.
                    if (w_lock_rise) begin
                        r_timer <= STRIKE_LOAD;
                    end else if (r_timer == '0) begin
                        r_state  <= ST_ARMED;
                        r_strike <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                ST_LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state    <= ST_ARMED;
                        r_fail_cnt <= '0;
                        r_lockout  <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                default: begin
                    r_state   <= ST_ARMED;
                    r_timer   <= '0;
                    r_strike  <= 1'b0;
                    r_lockout <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lockcomp = r_lockcomp;
    assign bus.strike   = r_strike;
    assign bus.lockout  = r_lockout;
    assign bus.fail_cnt = r_fail_cnt;
    assign bus.prog_ack = r_prog_ack;
endmodule
